// File: rtl/miriscv_mem_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Define MIRISCV_ARB_RR_EN for round-robin arbitration; otherwise data always beats instruction.
module miriscv_mem_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned XLEN           = 32
) (
    input  logic                clk_i,
    input  logic                rst_i,

    input  logic                instr_req_i,
    input  logic [XLEN-1:0]     instr_addr_i,
    output logic                instr_rvalid_o,
    output logic [XLEN-1:0]     instr_rdata_o,

    input  logic                data_req_i,
    input  logic                data_we_i,
    input  logic [XLEN/8-1:0]   data_be_i,
    input  logic [XLEN-1:0]     data_addr_i,
    input  logic [XLEN-1:0]     data_wdata_i,
    output logic                data_rvalid_o,
    output logic [XLEN-1:0]     data_rdata_o,

    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [XLEN/8-1:0]   mem_be_o,
    output logic [XLEN-1:0]     mem_addr_o,
    output logic [XLEN-1:0]     mem_wdata_o,
    input  logic                mem_gnt_i,
    input  logic                mem_rvalid_i,
    input  logic [XLEN-1:0]     mem_rdata_i,

    output logic                err_o
);

    localparam logic [15:0] LP_TIMEOUT = (TIMEOUT_CYCLES > 32'hFFFF) ? 16'hFFFF
                                                                     : 16'(TIMEOUT_CYCLES);
    localparam bit          LP_TO_EN   = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_owner;      // 0 = instruction, 1 = data
    logic [15:0]         r_cnt;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [XLEN/8-1:0]   r_mem_be;
    logic [XLEN-1:0]     r_mem_addr;
    logic [XLEN-1:0]     r_mem_wdata;

    logic                w_any_req;
    logic                w_pick_data;
    logic                w_in_wait;
    logic                w_expire;
    logic                w_resp;

    assign w_any_req = instr_req_i | data_req_i;

`ifdef MIRISCV_ARB_RR_EN
    logic r_last_data;

    // On a tie the requester that was not served last gets the port.
    assign w_pick_data = data_req_i & (~instr_req_i | ~r_last_data);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_last_data <= 1'b0;
        end else if (r_state == S_IDLE && w_any_req) begin
            r_last_data <= w_pick_data;
        end
    end
`else
    assign w_pick_data = data_req_i;
`endif

    // Responses are routed combinationally; a reset cycle swallows any in-flight response.
    assign w_in_wait = (r_state == S_WAIT) && !rst_i;
    assign w_expire  = w_in_wait && LP_TO_EN && (r_cnt == LP_TIMEOUT) && !mem_rvalid_i;
    assign w_resp    = w_in_wait && (mem_rvalid_i || w_expire);

    assign instr_rvalid_o = w_resp & ~r_owner;
    assign data_rvalid_o  = w_resp &  r_owner;
    assign instr_rdata_o  = (instr_rvalid_o && mem_rvalid_i) ? mem_rdata_i : '0;
    assign data_rdata_o   = (data_rvalid_o  && mem_rvalid_i) ? mem_rdata_i : '0;
    assign err_o          = w_expire;

    assign mem_req_o   = r_mem_req;
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_owner     <= 1'b0;
            r_cnt       <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_owner   <= w_pick_data;
                        r_mem_req <= 1'b1;
                        r_state   <= S_REQ;
                        if (w_pick_data) begin
                            r_mem_we    <= data_we_i;
                            r_mem_be    <= data_be_i;
                            r_mem_addr  <= data_addr_i;
                            r_mem_wdata <= data_wdata_i;
                        end else begin
                            r_mem_we    <= 1'b0;
                            r_mem_be    <= '1;
                            r_mem_addr  <= instr_addr_i;
                            r_mem_wdata <= '0;
                        end
                    end
                end
                S_REQ: begin
                    // An rvalid alongside the grant is not a response to this request.
                    if (mem_gnt_i) begin
                        r_mem_req <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (w_resp) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt != 16'hFFFF) begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Directed bench for miriscv_mem_arbiter, built with TIMEOUT_CYCLES=4.
// Inputs change 1 time unit after the rising edge; outputs are checked 1 unit later.
module tb_miriscv_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_rvalid_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i;
    logic        data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic        data_rvalid_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        err_o;

    int vecs = 0;
    int errs = 0;

    miriscv_mem_arbiter #(.TIMEOUT_CYCLES(4), .XLEN(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
        .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
        .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
        .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic clear_inputs();
        instr_req_i = 0; instr_addr_i = 0;
        data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_i = 1;
        nxt();
        nxt();
        mem_rvalid_i = 1; mem_rdata_i = 32'hFFFF_FFFF;
        #1;
        vecs++;
        if ({mem_req_o, mem_we_o, mem_be_o, instr_rvalid_o, data_rvalid_o, err_o} !== 9'b0 ||
            mem_addr_o !== 0 || mem_wdata_o !== 0 || instr_rdata_o !== 0 || data_rdata_o !== 0) begin
            $display("FAIL reset_outputs: req=%b we=%b be=%h addr=%h wdata=%h irv=%b drv=%b ird=%h drd=%h err=%b, want all 0",
                     mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
                     instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o, err_o);
            errs++;
        end
        nxt();
        rst_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        nxt();
        #1;
        vecs++;
        if ({mem_req_o, instr_rvalid_o, data_rvalid_o, err_o} !== 4'b0) begin
            $display("FAIL reset_idle: req=%b irv=%b drv=%b err=%b, want 0000",
                     mem_req_o, instr_rvalid_o, data_rvalid_o, err_o);
            errs++;
        end
    endtask

    task automatic test_single_fetch();
        instr_req_i = 1; instr_addr_i = 32'h80;
        #1;
        vecs++;
        if (mem_req_o !== 1'b0) begin
            $display("FAIL fetch_idle_req: got %b want 0", mem_req_o); errs++;
        end
        nxt();
        mem_gnt_i = 1;
        #1;
        vecs++;
        if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b10_1111 || mem_addr_o !== 32'h80 ||
            instr_rvalid_o !== 1'b0) begin
            $display("FAIL fetch_req: req/we/be=%b addr=%h irv=%b, want 101111 00000080 0",
                     {mem_req_o, mem_we_o, mem_be_o}, mem_addr_o, instr_rvalid_o);
            errs++;
        end
        nxt();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013;
        #1;
        vecs++;
        if ({mem_req_o, instr_rvalid_o, data_rvalid_o, err_o} !== 4'b0100 ||
            instr_rdata_o !== 32'h13 || data_rdata_o !== 0) begin
            $display("FAIL fetch_resp: req/irv/drv/err=%b ird=%h drd=%h, want 0100 00000013 0",
                     {mem_req_o, instr_rvalid_o, data_rvalid_o, err_o}, instr_rdata_o, data_rdata_o);
            errs++;
        end
        nxt();
        instr_req_i = 0; mem_rvalid_i = 0;
        #1;
        vecs++;
        if ({mem_req_o, instr_rvalid_o} !== 2'b00 || instr_rdata_o !== 0) begin
            $display("FAIL fetch_after: req/irv=%b ird=%h, want 00 0",
                     {mem_req_o, instr_rvalid_o}, instr_rdata_o);
            errs++;
        end
        nxt();
    endtask

    task automatic test_priority();
        data_req_i = 1; data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h100; data_wdata_i = 32'hBEEF;
        instr_req_i = 1; instr_addr_i = 32'h84;
        nxt();
        mem_gnt_i = 1;
        #1;
        vecs++;
        if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b11_0011 || mem_addr_o !== 32'h100 ||
            mem_wdata_o !== 32'hBEEF) begin
            $display("FAIL prio_store_first: req/we/be=%b addr=%h wdata=%h, want 110011 00000100 0000beef",
                     {mem_req_o, mem_we_o, mem_be_o}, mem_addr_o, mem_wdata_o);
            errs++;
        end
        nxt();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 0;
        #1;
        vecs++;
        if ({instr_rvalid_o, data_rvalid_o, err_o} !== 3'b010) begin
            $display("FAIL prio_store_resp: irv/drv/err=%b want 010", {instr_rvalid_o, data_rvalid_o, err_o});
            errs++;
        end
        nxt();
        data_req_i = 0; data_we_i = 0; mem_rvalid_i = 0;
        nxt();
        mem_gnt_i = 1;
        #1;
        vecs++;
        if ({mem_req_o, mem_we_o, mem_be_o} !== 6'b10_1111 || mem_addr_o !== 32'h84 ||
            mem_wdata_o !== 0) begin
            $display("FAIL prio_fetch_next: req/we/be=%b addr=%h wdata=%h, want 101111 00000084 0",
                     {mem_req_o, mem_we_o, mem_be_o}, mem_addr_o, mem_wdata_o);
            errs++;
        end
        nxt();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0093;
        #1;
        vecs++;
        if ({instr_rvalid_o, data_rvalid_o} !== 2'b10 || instr_rdata_o !== 32'h93) begin
            $display("FAIL prio_fetch_resp: irv/drv=%b ird=%h, want 10 00000093",
                     {instr_rvalid_o, data_rvalid_o}, instr_rdata_o);
            errs++;
        end
        nxt();
        instr_req_i = 0; mem_rvalid_i = 0;
        nxt();
    endtask

    task automatic test_stall();
        data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h200;
        nxt();
        for (int i = 0; i < 5; i++) begin
            #1;
            vecs++;
            if ({mem_req_o, data_rvalid_o, err_o} !== 3'b100 || mem_addr_o !== 32'h200 ||
                mem_be_o !== 4'hF || mem_we_o !== 1'b0) begin
                $display("FAIL stall_hold[%0d]: req/drv/err=%b addr=%h be=%h we=%b, want 100 00000200 f 0",
                         i, {mem_req_o, data_rvalid_o, err_o}, mem_addr_o, mem_be_o, mem_we_o);
                errs++;
            end
            nxt();
        end
        // Sixth REQ cycle: grant arrives together with a stray rvalid.
        mem_gnt_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h1111_1111;
        #1;
        vecs++;
        if ({mem_req_o, data_rvalid_o, err_o} !== 3'b100 || data_rdata_o !== 0) begin
            $display("FAIL stall_gnt_rvalid: req/drv/err=%b drd=%h, want 100 0",
                     {mem_req_o, data_rvalid_o, err_o}, data_rdata_o);
            errs++;
        end
        nxt();
        mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE;
        #1;
        vecs++;
        if ({mem_req_o, data_rvalid_o, err_o} !== 3'b010 || data_rdata_o !== 32'hCAFE) begin
            $display("FAIL stall_resp: req/drv/err=%b drd=%h, want 010 0000cafe",
                     {mem_req_o, data_rvalid_o, err_o}, data_rdata_o);
            errs++;
        end
        nxt();
        data_req_i = 0; mem_rvalid_i = 0;
        nxt();
    endtask

    task automatic test_timeout();
        data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h300;
        nxt();
        mem_gnt_i = 1;
        nxt();
        mem_gnt_i = 0; mem_rdata_i = 32'hFFFF_FFFF;
        for (int i = 0; i < 4; i++) begin
            #1;
            vecs++;
            if ({data_rvalid_o, err_o} !== 2'b00) begin
                $display("FAIL timeout_wait[%0d]: drv/err=%b want 00", i, {data_rvalid_o, err_o});
                errs++;
            end
            nxt();
        end
        #1;
        vecs++;
        if ({instr_rvalid_o, data_rvalid_o, err_o} !== 3'b011 || data_rdata_o !== 0) begin
            $display("FAIL timeout_fire: irv/drv/err=%b drd=%h, want 011 0",
                     {instr_rvalid_o, data_rvalid_o, err_o}, data_rdata_o);
            errs++;
        end
        nxt();
        data_req_i = 0;
        #1;
        vecs++;
        if ({mem_req_o, data_rvalid_o, err_o} !== 3'b000) begin
            $display("FAIL timeout_after: req/drv/err=%b want 000", {mem_req_o, data_rvalid_o, err_o});
            errs++;
        end
        nxt();
        mem_rvalid_i = 1; mem_rdata_i = 32'h55;
        #1;
        vecs++;
        if ({instr_rvalid_o, data_rvalid_o, err_o} !== 3'b000 || data_rdata_o !== 0 || instr_rdata_o !== 0) begin
            $display("FAIL timeout_late_rvalid: irv/drv/err=%b drd=%h ird=%h, want 000 0 0",
                     {instr_rvalid_o, data_rvalid_o, err_o}, data_rdata_o, instr_rdata_o);
            errs++;
        end
        nxt();
        mem_rvalid_i = 0; mem_rdata_i = 0;
        nxt();
    endtask

    task automatic test_coincide();
        data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h340;
        nxt();
        mem_gnt_i = 1;
        nxt();
        mem_gnt_i = 0;
        for (int i = 0; i < 4; i++) nxt();
        mem_rvalid_i = 1; mem_rdata_i = 32'h1234_5678;
        #1;
        vecs++;
        if ({data_rvalid_o, err_o} !== 2'b10 || data_rdata_o !== 32'h1234_5678) begin
            $display("FAIL coincide: drv/err=%b drd=%h, want 10 12345678",
                     {data_rvalid_o, err_o}, data_rdata_o);
            errs++;
        end
        nxt();
        data_req_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        nxt();
    endtask

    task automatic test_reset_mid();
        data_req_i = 1; data_we_i = 1; data_be_i = 4'h3; data_addr_i = 32'h500; data_wdata_i = 32'hA5A5;
        nxt();
        mem_gnt_i = 1;
        nxt();
        mem_gnt_i = 0; rst_i = 1; mem_rvalid_i = 1; mem_rdata_i = 32'h77;
        #1;
        vecs++;
        if ({instr_rvalid_o, data_rvalid_o, err_o} !== 3'b000 || data_rdata_o !== 0) begin
            $display("FAIL rstmid_rvalid: irv/drv/err=%b drd=%h, want 000 0",
                     {instr_rvalid_o, data_rvalid_o, err_o}, data_rdata_o);
            errs++;
        end
        nxt();
        rst_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0; data_req_i = 0; data_we_i = 0;
        #1;
        vecs++;
        if ({mem_req_o, mem_we_o, mem_be_o, data_rvalid_o, err_o} !== 8'b0 ||
            mem_addr_o !== 0 || mem_wdata_o !== 0) begin
            $display("FAIL rstmid_outputs: req/we/be/drv/err=%b addr=%h wdata=%h, want 0 0 0",
                     {mem_req_o, mem_we_o, mem_be_o, data_rvalid_o, err_o}, mem_addr_o, mem_wdata_o);
            errs++;
        end
        nxt();
        #1;
        vecs++;
        if (mem_req_o !== 1'b0) begin
            $display("FAIL rstmid_idle: req=%b want 0", mem_req_o); errs++;
        end
    endtask

    task automatic test_conflict_repeat();
        logic exp_data;
        data_req_i = 1; data_we_i = 0; data_be_i = 4'hF; data_addr_i = 32'h600;
        instr_req_i = 1; instr_addr_i = 32'h700;
        for (int k = 0; k < 4; k++) begin
`ifdef MIRISCV_ARB_RR_EN
            exp_data = (k % 2 == 0);
`else
            exp_data = 1'b1;
`endif
            #1;
            vecs++;
            if (mem_req_o !== 1'b0) begin
                $display("FAIL conflict_idle[%0d]: req=%b want 0", k, mem_req_o); errs++;
            end
            nxt();
            mem_gnt_i = 1;
            #1;
            vecs++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== (exp_data ? 32'h600 : 32'h700)) begin
                $display("FAIL conflict_addr[%0d]: req=%b addr=%h, want 1 %h",
                         k, mem_req_o, mem_addr_o, exp_data ? 32'h600 : 32'h700);
                errs++;
            end
            nxt();
            mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'hD0 + k;
            #1;
            vecs++;
            if ({data_rvalid_o, instr_rvalid_o} !== {exp_data, ~exp_data}) begin
                $display("FAIL conflict_owner[%0d]: drv/irv=%b want %b",
                         k, {data_rvalid_o, instr_rvalid_o}, {exp_data, ~exp_data});
                errs++;
            end
            nxt();
            mem_rvalid_i = 0;
        end
        instr_req_i = 0; data_req_i = 0;
        nxt();
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 3; k++) begin
            instr_req_i = 1; instr_addr_i = 32'h1000 + 4 * k; mem_rvalid_i = 0;
            #1;
            vecs++;
            if ({mem_req_o, instr_rvalid_o} !== 2'b00) begin
                $display("FAIL b2b_idle[%0d]: req/irv=%b want 00", k, {mem_req_o, instr_rvalid_o});
                errs++;
            end
            nxt();
            mem_gnt_i = 1;
            #1;
            vecs++;
            if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h1000 + 4 * k) begin
                $display("FAIL b2b_req[%0d]: req=%b addr=%h, want 1 %h",
                         k, mem_req_o, mem_addr_o, 32'h1000 + 4 * k);
                errs++;
            end
            nxt();
            mem_gnt_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h100 + k;
            #1;
            vecs++;
            if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h100 + k) begin
                $display("FAIL b2b_resp[%0d]: irv=%b ird=%h, want 1 %h",
                         k, instr_rvalid_o, instr_rdata_o, 32'h100 + k);
                errs++;
            end
            nxt();
        end
        instr_req_i = 0; mem_rvalid_i = 0; mem_rdata_i = 0;
        nxt();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_priority();
        test_stall();
        test_timeout();
        test_coincide();
        test_reset_mid();
        test_conflict_repeat();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
